// File: rtl/regfile_pkg.sv
// Shared register-file types and constants, also used by the dual read-port multiplexor.
package regfile_pkg;

  localparam int NREG_C     = 32;
  localparam int WIDTH_C    = 64;
  localparam int ZERO_REG_C = 31;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [63:0]       word_t;
  typedef logic [31:0][63:0] reg_array_t;

endpackage

// File: rtl/regfile_write_bank_decoder5to32.sv
// One-hot 5-to-32 decoder with enable; all outputs low when en is low.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic        en,
  input  reg_idx_t    sel,
  output logic [31:0] out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the register file: storage, write decode, XZR hardwiring and pending-write scoreboard.
// Optional macro REGFILE_WRITE_FWD_EN enables same-cycle write-through on regs_out and hazard outputs.
module regfile_write_bank
  import regfile_pkg::*;
#(
  parameter int NREG     = NREG_C,
  parameter int WIDTH    = WIDTH_C,
  parameter int ZERO_REG = ZERO_REG_C
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [4:0]                 wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       issue_en,
  input  logic [4:0]                 issue_addr,
  input  logic [4:0]                 chk_addr1,
  input  logic [4:0]                 chk_addr2,
  output logic [NREG-1:0][WIDTH-1:0] regs_out,
  output logic [NREG-1:0]            pending,
  output logic                       hazard1,
  output logic                       hazard2
);

  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d, regs_vis;
  logic [NREG-1:0]            pending_q, pending_d, pend_vis;
  logic [31:0]                wr_dec, iss_dec;

  decoder5to32 u_wr_dec (
    .en  (wr_en),
    .sel (wr_addr),
    .out (wr_dec)
  );

  decoder5to32 u_iss_dec (
    .en  (issue_en),
    .sel (issue_addr),
    .out (iss_dec)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_dec[i]) regs_d[i] = wr_data;
    end
    regs_d[ZERO_REG] = '0;
  end

  // Clear before set so a same-cycle re-issue of the written register keeps it pending.
  always_comb begin
    pending_d           = (pending_q & ~wr_dec) | iss_dec;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    regs_vis = regs_q;
    pend_vis = pending_q;
`ifdef REGFILE_WRITE_FWD_EN
    for (int i = 0; i < NREG; i++) begin
      if (wr_dec[i]) regs_vis[i] = wr_data;
    end
    pend_vis = pending_q & ~(wr_dec & ~iss_dec);
`endif
    regs_vis[ZERO_REG] = '0;
  end

  assign regs_out = regs_vis;
  assign pending  = pending_q;
  assign hazard1  = pend_vis[chk_addr1];
  assign hazard2  = pend_vis[chk_addr2];

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: directed vector table, hand sequences and random stimulus.
module tb_regfile_write_bank;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  reg_idx_t          wr_addr;
  word_t             wr_data;
  logic              issue_en;
  reg_idx_t          issue_addr;
  reg_idx_t          chk_addr1;
  reg_idx_t          chk_addr2;
  logic [31:0][63:0] regs_out;
  logic [31:0]       pending;
  logic              hazard1;
  logic              hazard2;

  int compared   = 0;
  int mismatched = 0;

`ifdef REGFILE_WRITE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  regfile_write_bank dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .chk_addr1  (chk_addr1),
    .chk_addr2  (chk_addr2),
    .regs_out   (regs_out),
    .pending    (pending),
    .hazard1    (hazard1),
    .hazard2    (hazard2)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register values and pending flags.
  word_t m_regs[32];
  bit    m_pend[32];

  typedef struct {
    logic        rst;
    logic        we;
    reg_idx_t    wa;
    word_t       wd;
    logic        ie;
    reg_idx_t    ia;
    reg_idx_t    c1;
    reg_idx_t    c2;
    logic [31:0] exp_pend;
    logic        exp_h1;
    logic        exp_h2;
    reg_idx_t    reg_sel;
    word_t       exp_val;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic we, input reg_idx_t wa, input word_t wd,
                            input logic ie, input reg_idx_t ia);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 5'd31) m_regs[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (ie && ia != 5'd31) m_pend[ia] = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic go_idle();
    reset    = 1'b0;
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  task automatic apply_cycle(input logic rst, input logic we, input reg_idx_t wa, input word_t wd,
                             input logic ie, input reg_idx_t ia);
    reset      = rst;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    @(posedge clk);
    model_step(rst, we, wa, wd, ie, ia);
    #1;
    go_idle();
  endtask

  task automatic check_all(input reg_idx_t c1, input reg_idx_t c2);
    chk_addr1 = c1;
    chk_addr2 = c2;
    #1;
    for (int i = 0; i < 32; i++) check($sformatf("regs_out[%0d]", i), regs_out[i], m_regs[i]);
    check("pending", {32'd0, pending}, {32'd0, model_pend_vec()});
    check("hazard1", {63'd0, hazard1}, {63'd0, m_pend[c1]});
    check("hazard2", {63'd0, hazard2}, {63'd0, m_pend[c2]});
  endtask

  function automatic reg_idx_t rand_idx();
    if ($urandom_range(0, 1) == 0) return reg_idx_t'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return reg_idx_t'($urandom_range(0, 31));
  endfunction

  initial begin
    logic     r_rst, r_we, r_ie;
    reg_idx_t r_wa, r_ia, r_c1, r_c2;
    word_t    r_wd;
    logic     exp_h;
    word_t    exp_w;

    reset = 1'b1; wr_en = 1'b0; issue_en = 1'b0;
    wr_addr = '0; wr_data = '0; issue_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 64'hBAD0_BAD0_BAD0_BAD0;
      m_pend[i] = 1'b1;
    end

    //          rst   we    wa     wd                       ie    ia     c1     c2     pend        h1    h2    reg    value
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd0,  5'd1,  32'h0,      1'b0, 1'b0, 5'd0,  64'h0};
    vecs[1]  = '{1'b1, 1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd7,  5'd31, 32'h0,      1'b0, 1'b0, 5'd5,  64'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0,  5'd5,  5'd0,  32'h0,      1'b0, 1'b0, 5'd5,  64'hDEAD_BEEF_0123_4567};
    vecs[3]  = '{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0,  5'd31, 5'd5,  32'h0,      1'b0, 1'b0, 5'd31, 64'h0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  64'h0,                   1'b1, 5'd31, 5'd31, 5'd0,  32'h0,      1'b0, 1'b0, 5'd31, 64'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  64'h0,                   1'b1, 5'd7,  5'd7,  5'd5,  32'h80,     1'b1, 1'b0, 5'd7,  64'h0};
    vecs[6]  = '{1'b0, 1'b1, 5'd7,  64'h42,                  1'b0, 5'd0,  5'd7,  5'd5,  32'h0,      1'b0, 1'b0, 5'd7,  64'h42};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,                   1'b1, 5'd3,  5'd3,  5'd7,  32'h08,     1'b1, 1'b0, 5'd3,  64'h0};
    vecs[8]  = '{1'b0, 1'b1, 5'd3,  64'h33,                  1'b1, 5'd3,  5'd3,  5'd4,  32'h08,     1'b1, 1'b0, 5'd3,  64'h33};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  64'h34,                  1'b1, 5'd4,  5'd3,  5'd4,  32'h10,     1'b0, 1'b1, 5'd3,  64'h34};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  64'h0,                   1'b1, 5'd3,  5'd3,  5'd4,  32'h18,     1'b1, 1'b1, 5'd3,  64'h34};
    vecs[11] = '{1'b1, 1'b1, 5'd9,  64'h99,                  1'b1, 5'd5,  5'd3,  5'd4,  32'h0,      1'b0, 1'b0, 5'd9,  64'h0};
    vecs[12] = '{1'b0, 1'b1, 5'd9,  64'h99,                  1'b0, 5'd0,  5'd9,  5'd5,  32'h0,      1'b0, 1'b0, 5'd9,  64'h99};

    for (int k = 0; k < 13; k++) begin
      apply_cycle(vecs[k].rst, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].ie, vecs[k].ia);
      check_all(vecs[k].c1, vecs[k].c2);
      check($sformatf("vec%0d pending", k), {32'd0, pending}, {32'd0, vecs[k].exp_pend});
      check($sformatf("vec%0d hazard1", k), {63'd0, hazard1}, {63'd0, vecs[k].exp_h1});
      check($sformatf("vec%0d hazard2", k), {63'd0, hazard2}, {63'd0, vecs[k].exp_h2});
      check($sformatf("vec%0d regs_out[%0d]", k, vecs[k].reg_sel), regs_out[vecs[k].reg_sel], vecs[k].exp_val);
    end

    // Same-cycle visibility of a write that retires a pending register.
    apply_cycle(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd6);
    check_all(5'd6, 5'd2);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h66;
    chk_addr1 = 5'd6; chk_addr2 = 5'd2;
    #1;
    check("same-cycle regs_out[6]", regs_out[6], FWD ? 64'h66 : 64'h0);
    check("same-cycle hazard1 on retiring write", {63'd0, hazard1}, {63'd0, !FWD});
    issue_en = 1'b1; issue_addr = 5'd6;
    #1;
    check("same-cycle hazard1 on re-issue", {63'd0, hazard1}, 64'd1);
    @(posedge clk);
    model_step(1'b0, 1'b1, 5'd6, 64'h66, 1'b1, 5'd6);
    #1;
    go_idle();
    check_all(5'd6, 5'd2);

    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h77;
    #1;
    check("same-cycle regs_out[2]", regs_out[2], FWD ? 64'h77 : 64'h0);
    @(posedge clk);
    model_step(1'b0, 1'b1, 5'd2, 64'h77, 1'b0, 5'd0);
    #1;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("same-cycle regs_out[31]", regs_out[31], 64'h0);
    @(posedge clk);
    model_step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0);
    #1;
    go_idle();
    check_all(5'd2, 5'd31);

    // Random traffic against the model, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = ($urandom_range(0, 2) != 0);
      r_ie  = ($urandom_range(0, 2) != 0);
      r_wa  = rand_idx();
      r_ia  = rand_idx();
      r_c1  = rand_idx();
      r_c2  = rand_idx();
      r_wd  = {$urandom, $urandom};
      reset = r_rst; wr_en = r_we; wr_addr = r_wa; wr_data = r_wd;
      issue_en = r_ie; issue_addr = r_ia; chk_addr1 = r_c1; chk_addr2 = r_c2;
      #1;
      exp_h = m_pend[r_c1];
      if (FWD && r_we && r_wa == r_c1 && !(r_ie && r_ia == r_c1)) exp_h = 1'b0;
      check("rand same-cycle hazard1", {63'd0, hazard1}, {63'd0, exp_h});
      exp_w = m_regs[r_wa];
      if (FWD && r_we && r_wa != 5'd31) exp_w = r_wd;
      check("rand same-cycle regs_out[wr_addr]", regs_out[r_wa], exp_w);
      @(posedge clk);
      model_step(r_rst, r_we, r_wa, r_wd, r_ie, r_ia);
      #1;
      go_idle();
      check_all(rand_idx(), rand_idx());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
